// File: rtl/perf_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank_if
// Brief    : Control, event and read-port bundle for perf_counter_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface perf_counter_bank_if #(
    parameter int N_EVT = 8,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    logic             clr;
    logic             halt;
    logic [N_EVT-1:0] en;
    logic [N_EVT-1:0] evt;
    logic             snap;
    logic             rd_shadow;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] rd_data;
    logic [N_EVT-1:0] ovf;
    logic             halted;

    modport master (
        output clr, halt, en, evt, snap, rd_shadow, sel,
        input  rd_data, ovf, halted
    );

    modport slave (
        input  clr, halt, en, evt, snap, rd_shadow, sel,
        output rd_data, ovf, halted
    );
endinterface
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Brief    : N_EVT event counters (edge/level per channel), sticky overflow,
//            snapshot shadow bank and registered select-read port; freezes on
//            program halt. Build macro PERF_SAT_EN: saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
    parameter int               N_EVT     = 8,
    parameter int               CNT_W     = 32,
    parameter int               SEL_W     = 4,
    parameter logic [N_EVT-1:0] EDGE_MASK = '0
) (
    input  logic                clk,
    input  logic                RST,
    perf_counter_bank_if.slave  bus
);

    localparam logic [0:0]       c_ST_RUN    = 1'b0;
    localparam logic [0:0]       c_ST_HALTED = 1'b1;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ALL_ONES  = '1;

`ifdef PERF_SAT_EN
    localparam bit c_SATURATE = 1'b1;
`else
    localparam bit c_SATURATE = 1'b0;
`endif

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_running;
    logic [N_EVT-1:0] r_prev;
    logic [N_EVT-1:0] r_ovf;
    logic [N_EVT-1:0] w_inc;
    logic [CNT_W-1:0] r_cnt    [N_EVT];
    logic [CNT_W-1:0] r_shadow [N_EVT];
    logic [CNT_W-1:0] r_rd_data;
    logic [CNT_W-1:0] w_rd_mux;

    assign w_running = (r_state == c_ST_RUN);

    // ------------------------------------------------------------------
    // Run/halt state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:    if (bus.halt) w_state_nxt = c_ST_HALTED;
            c_ST_HALTED: w_state_nxt = c_ST_HALTED;
            default:     w_state_nxt = c_ST_RUN;
        endcase
        // Clear always wins over a same-cycle halt.
        if (bus.clr) begin
            w_state_nxt = c_ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel increment qualifier
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_EVT; gi++) begin : g_inc
            if (EDGE_MASK[gi]) begin : g_edge
                assign w_inc[gi] = w_running & bus.en[gi] & bus.evt[gi] & ~r_prev[gi];
            end else begin : g_level
                assign w_inc[gi] = w_running & bus.en[gi] & bus.evt[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Live counters, overflow flags and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_EVT; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf  <= '0;
            r_prev <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < N_EVT; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf  <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= bus.evt;
            for (int i = 0; i < N_EVT; i++) begin
                if (w_inc[i]) begin
                    if (r_cnt[i] == c_ALL_ONES) begin
                        r_ovf[i] <= 1'b1;
                        r_cnt[i] <= c_SATURATE ? c_ALL_ONES : '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + c_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow bank: captures the pre-update live values, even under clr
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_EVT; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (bus.snap) begin
            for (int i = 0; i < N_EVT; i++) begin
                r_shadow[i] <= r_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: unmatched select values fall through to zero
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                w_rd_mux = bus.rd_shadow ? r_shadow[i] : r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.ovf     = r_ovf;
    assign bus.halted  = (r_state == c_ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_counter_bank
// Brief    : Self-checking bench for perf_counter_bank (5 channels, 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;

    localparam int         N    = 5;
    localparam int         W    = 8;
    localparam int         S    = 3;
    localparam logic [4:0] EM   = 5'b00010;
    localparam int         MAXV = (1 << W) - 1;
`ifdef PERF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic RST;
    int   n_cmp;
    int   n_fail;

    perf_counter_bank_if #(.N_EVT(N), .CNT_W(W), .SEL_W(S)) bus ();

    perf_counter_bank #(
        .N_EVT     (N),
        .CNT_W     (W),
        .SEL_W     (S),
        .EDGE_MASK (EM)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integers per channel
    int         m_cnt    [N];
    int         m_shadow [N];
    bit         m_prev   [N];
    logic [4:0] m_ovf;
    bit         m_halted;
    int         m_rd;

    typedef struct {
        logic [4:0] en;
        logic [4:0] evt;
        logic [2:0] sel;
        logic [7:0] exp_rd;
        logic [4:0] exp_ovf;
        logic       exp_halted;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]    = 0;
            m_shadow[i] = 0;
            m_prev[i]   = 1'b0;
        end
        m_ovf    = '0;
        m_halted = 1'b0;
        m_rd     = 0;
    endtask

    task automatic model_edge();
        int  nxt_rd;
        bit  hit;
        nxt_rd = 0;
        if (int'(bus.sel) < N) begin
            nxt_rd = bus.rd_shadow ? m_shadow[int'(bus.sel)] : m_cnt[int'(bus.sel)];
        end
        if (bus.snap) begin
            for (int i = 0; i < N; i++) m_shadow[i] = m_cnt[i];
        end
        if (bus.clr) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_prev[i] = 1'b0;
            end
            m_ovf    = '0;
            m_halted = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hit = bus.en[i] && bus.evt[i] && !(EM[i] && m_prev[i]);
                if (!m_halted && hit) begin
                    if (m_cnt[i] + 1 > MAXV) begin
                        m_ovf[i] = 1'b1;
                        m_cnt[i] = SAT ? MAXV : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                m_prev[i] = bus.evt[i];
            end
            if (bus.halt) m_halted = 1'b1;
        end
        m_rd = nxt_rd;
    endtask

    task automatic drv(input logic c, input logic h, input logic [4:0] e, input logic [4:0] v,
                       input logic sn, input logic rs, input logic [2:0] sl);
        bus.clr       = c;
        bus.halt      = h;
        bus.en        = e;
        bus.evt       = v;
        bus.snap      = sn;
        bus.rd_shadow = rs;
        bus.sel       = sl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_rd_data", 64'(bus.rd_data), 64'(m_rd));
        check("model_ovf", 64'(bus.ovf), 64'(m_ovf));
        check("model_halted", 64'(bus.halted), 64'(m_halted));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // edge channel 1 and level channel 2 see the same pattern 1,1,0,1,0,0,1
        tbl[0] = '{5'b00110, 5'b00110, 3'd1, 8'd0, 5'd0, 1'b0};
        tbl[1] = '{5'b00110, 5'b00110, 3'd1, 8'd1, 5'd0, 1'b0};
        tbl[2] = '{5'b00110, 5'b00000, 3'd1, 8'd1, 5'd0, 1'b0};
        tbl[3] = '{5'b00110, 5'b00110, 3'd1, 8'd1, 5'd0, 1'b0};
        tbl[4] = '{5'b00110, 5'b00000, 3'd1, 8'd2, 5'd0, 1'b0};
        tbl[5] = '{5'b00110, 5'b00000, 3'd1, 8'd2, 5'd0, 1'b0};
        tbl[6] = '{5'b00110, 5'b00110, 3'd1, 8'd2, 5'd0, 1'b0};
        tbl[7] = '{5'b00110, 5'b00000, 3'd1, 8'd3, 5'd0, 1'b0};
        tbl[8] = '{5'b00110, 5'b00000, 3'd2, 8'd4, 5'd0, 1'b0};

        RST = 1'b0;
        drv(0, 0, 5'd0, 5'd0, 0, 0, 3'd0);
        model_reset();
        #12;
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        check("reset_ovf", 64'(bus.ovf), 64'd0);
        check("reset_halted", 64'(bus.halted), 64'd0);
        #11 RST = 1'b1;

        // Level count of 10 on channel 0
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        for (int k = 0; k < 10; k++) step();
        drv(0, 0, 5'b00001, 5'b00000, 0, 0, 3'd0);
        step();
        check("t1_count10", 64'(bus.rd_data), 64'd10);
        check("t1_ovf", 64'(bus.ovf), 64'd0);

        // Edge vs level table
        drv(1, 0, 5'd0, 5'd0, 0, 0, 3'd0);
        step();
        for (int k = 0; k < 9; k++) begin
            drv(0, 0, tbl[k].en, tbl[k].evt, 0, 0, tbl[k].sel);
            step();
            check($sformatf("tbl%0d_rd", k), 64'(bus.rd_data), 64'(tbl[k].exp_rd));
            check($sformatf("tbl%0d_ovf", k), 64'(bus.ovf), 64'(tbl[k].exp_ovf));
            check($sformatf("tbl%0d_halted", k), 64'(bus.halted), 64'(tbl[k].exp_halted));
        end

        // Halt freezes counting; clr resumes
        drv(1, 0, 5'b00001, 5'd0, 0, 0, 3'd0);
        step();
        for (int k = 1; k <= 5; k++) begin
            drv(0, (k == 5), 5'b00001, 5'b00001, 0, 0, 3'd0);
            step();
        end
        check("t3_halted", 64'(bus.halted), 64'd1);
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        for (int k = 0; k < 20; k++) step();
        step();
        check("t3_frozen5", 64'(bus.rd_data), 64'd5);
        drv(1, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        step();
        check("t3_clr_halted", 64'(bus.halted), 64'd0);
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        step();
        check("t3_after_clr0", 64'(bus.rd_data), 64'd0);
        step();
        check("t3_resume1", 64'(bus.rd_data), 64'd1);

        // Overflow at 8 bits
        drv(1, 0, 5'b00001, 5'd0, 0, 0, 3'd0);
        step();
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        for (int k = 0; k < 255; k++) step();
        drv(0, 0, 5'b00001, 5'b00000, 0, 0, 3'd0);
        step();
        check("t4_255", 64'(bus.rd_data), 64'd255);
        check("t4_no_ovf", 64'(bus.ovf), 64'd0);
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        step();
        drv(0, 0, 5'b00001, 5'b00000, 0, 0, 3'd0);
        step();
        check("t4_wrap_value", 64'(bus.rd_data), SAT ? 64'd255 : 64'd0);
        check("t4_ovf_set", 64'(bus.ovf), 64'd1);
        for (int k = 0; k < 3; k++) step();
        check("t4_ovf_sticky", 64'(bus.ovf), 64'd1);
        drv(1, 0, 5'b00001, 5'd0, 0, 0, 3'd0);
        step();
        check("t4_ovf_clr", 64'(bus.ovf), 64'd0);

        // Snapshot timing
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        for (int k = 0; k < 7; k++) step();
        drv(0, 0, 5'b00001, 5'b00001, 1, 0, 3'd0);
        step();
        drv(0, 0, 5'b00001, 5'b00000, 0, 1, 3'd0);
        step();
        check("t5_shadow7", 64'(bus.rd_data), 64'd7);
        drv(0, 0, 5'b00001, 5'b00000, 0, 0, 3'd0);
        step();
        check("t5_live8", 64'(bus.rd_data), 64'd8);
        drv(0, 0, 5'b00001, 5'b00001, 0, 0, 3'd0);
        for (int k = 0; k < 4; k++) step();
        drv(1, 0, 5'b00001, 5'b00001, 1, 0, 3'd0);
        step();
        drv(0, 0, 5'b00001, 5'b00000, 0, 1, 3'd0);
        step();
        check("t5_shadow12", 64'(bus.rd_data), 64'd12);
        drv(0, 0, 5'b00001, 5'b00000, 0, 0, 3'd0);
        step();
        check("t5_live0", 64'(bus.rd_data), 64'd0);

        // Disabled channel, out-of-range select, async reset
        drv(0, 0, 5'b10111, 5'b11111, 0, 0, 3'd3);
        for (int k = 0; k < 6; k++) step();
        drv(0, 0, 5'b10111, 5'b00000, 0, 0, 3'd3);
        step();
        check("t6_en_off", 64'(bus.rd_data), 64'd0);
        drv(0, 0, 5'b10111, 5'b00000, 0, 0, 3'd6);
        step();
        check("t6_sel_oob", 64'(bus.rd_data), 64'd0);
        drv(0, 1, 5'b10111, 5'b00000, 0, 0, 3'd4);
        step();
        check("t6_pre_rst_rd", 64'(bus.rd_data), 64'd6);
        check("t6_pre_rst_halted", 64'(bus.halted), 64'd1);
        #3 RST = 1'b0;
        #1;
        check("t6_async_rd", 64'(bus.rd_data), 64'd0);
        check("t6_async_ovf", 64'(bus.ovf), 64'd0);
        check("t6_async_halted", 64'(bus.halted), 64'd0);
        model_reset();
        drv(0, 0, 5'd0, 5'd0, 0, 0, 3'd0);
        #2 RST = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drv(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 149) == 0),
                5'($urandom),
                5'($urandom),
                ($urandom_range(0, 7) == 0),
                1'($urandom),
                3'($urandom_range(0, 7)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
